// File: rtl/lvds_input_capture_sequencer_if.sv
// Sequencer <-> LVDS receiver control bundle: start controls and latched packet
// configuration out to the receiver, packet-complete/idle flag back.
interface lvds_input_capture_sequencer_if;
  logic        rx_start;
  logic        rx_start_rt;
  logic [31:0] rx_dsize;
  logic        rx_test;
  logic        rx_sr_pc;

  modport master (
    output rx_start,
    output rx_start_rt,
    output rx_dsize,
    output rx_test,
    input  rx_sr_pc
  );

  modport slave (
    input  rx_start,
    input  rx_start_rt,
    input  rx_dsize,
    input  rx_test,
    output rx_sr_pc
  );
endinterface

// File: rtl/lvds_input_capture_sequencer.sv
// Burst sequencer for an LVDS capture receiver: packet bursts or a real-time run.
// Optional watchdog on the receiver handshakes is enabled with LVDS_SEQ_TIMEOUT_EN.
module lvds_input_capture_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cmd_start,
  input  logic                   cmd_abort,
  input  logic                   cfg_mode,
  input  logic [31:0]            cfg_dsize,
  input  logic                   cfg_test,
  input  logic [CNT_W-1:0]       cfg_npackets,
  input  logic [CNT_W-1:0]       cfg_gap,
  input  logic [31:0]            cfg_timeout,
  lvds_input_capture_sequencer_if.master rx,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout,
  output logic [CNT_W-1:0]       pkt_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_GAP,
    S_RT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      dsize_q;
  logic             test_q;
  logic             mode_q;
  logic [CNT_W-1:0] npkt_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_inc;
  logic             abort_pend_q, abort_pend_d;
  logic             latch_en;
  logic             rx_start_q;
  logic             rt_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

`ifdef LVDS_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  // Only states that wait on the receiver are guarded.
  function automatic logic wd_state(input state_t s);
    return (s == S_ARM) || (s == S_WAIT_LOW) || (s == S_WAIT_HIGH) || (s == S_DRAIN);
  endfunction
`else
  logic unused_cfg_timeout;
  assign unused_cfg_timeout = ^cfg_timeout;
`endif

  assign pkt_cnt_inc = sat_inc(pkt_cnt_q);

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    abort_pend_d = abort_pend_q;
    latch_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          latch_en     = 1'b1;
          pkt_cnt_d    = '0;
          abort_pend_d = 1'b0;
          state_d      = S_ARM;
        end
      end
      S_ARM: begin
        if (cmd_abort) begin
          state_d = S_DONE;
        end else if (rx.rx_sr_pc) begin
          state_d = mode_q ? S_RT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        if (!rx.rx_sr_pc) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (cmd_abort) abort_pend_d = 1'b1;
        // The packet in flight always finishes; abort is honoured only here.
        if (rx.rx_sr_pc) begin
          pkt_cnt_d = pkt_cnt_inc;
          if (abort_pend_q || cmd_abort ||
              ((npkt_q != '0) && (pkt_cnt_inc == npkt_q))) begin
            state_d = S_DONE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cmd_abort) begin
          state_d = S_DONE;
        end else if (gap_cnt_q <= CNT_W'(1)) begin
          state_d = S_ARM;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      S_RT: begin
        if (cmd_abort) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rx.rx_sr_pc) begin
          pkt_cnt_d = pkt_cnt_inc;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef LVDS_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
    if ((cfg_timeout != 32'd0) && wd_state(state_q) &&
        (wd_cnt_q == cfg_timeout - 32'd1)) begin
      timeout_hit = 1'b1;
      state_d     = S_IDLE;
      pkt_cnt_d   = pkt_cnt_q;
    end
    wd_cnt_d = ((state_d == state_q) && wd_state(state_q)) ? wd_cnt_q + 32'd1 : 32'd0;
    if (timeout_hit) begin
      err_d = 1'b1;
    end else if (latch_en) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
`endif
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      dsize_q      <= '0;
      test_q       <= 1'b0;
      mode_q       <= 1'b0;
      npkt_q       <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      pkt_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      rx_start_q   <= 1'b0;
      rt_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      abort_pend_q <= abort_pend_d;
      if (latch_en) begin
        dsize_q <= cfg_dsize;
        test_q  <= cfg_test;
        mode_q  <= cfg_mode;
        npkt_q  <= cfg_npackets;
        gap_q   <= cfg_gap;
      end
      rx_start_q <= (state_d == S_ISSUE);
      rt_q       <= (state_d == S_RT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

`ifdef LVDS_SEQ_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign rx.rx_start    = rx_start_q;
  assign rx.rx_start_rt = rt_q;
  assign rx.rx_dsize    = dsize_q;
  assign rx.rx_test     = test_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pkt_count      = pkt_cnt_q;

endmodule

// File: tb/tb_lvds_input_capture_sequencer.sv
// Directed bench for lvds_input_capture_sequencer with a simple receiver model
// driving rx_sr_pc; timeout scenario depends on LVDS_SEQ_TIMEOUT_EN.
module tb_lvds_input_capture_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_start;
  logic        cmd_abort;
  logic        cfg_mode;
  logic [31:0] cfg_dsize;
  logic        cfg_test;
  logic [15:0] cfg_npackets;
  logic [15:0] cfg_gap;
  logic [31:0] cfg_timeout;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [15:0] pkt_count;

  lvds_input_capture_sequencer_if rx();

  lvds_input_capture_sequencer #(.CNT_W(16)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cmd_start    (cmd_start),
    .cmd_abort    (cmd_abort),
    .cfg_mode     (cfg_mode),
    .cfg_dsize    (cfg_dsize),
    .cfg_test     (cfg_test),
    .cfg_npackets (cfg_npackets),
    .cfg_gap      (cfg_gap),
    .cfg_timeout  (cfg_timeout),
    .rx           (rx),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .pkt_count    (pkt_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Receiver model: 0 = idle (rx_sr_pc held), 1 = packet, 2 = real-time.
  int model    = 0;
  int low_len  = 258;
  int low_cnt  = 0;
  bit rt_seen  = 1'b0;
  bit rx_completed;

  task automatic rx_step();
    rx_completed = 1'b0;
    if (model == 1) begin
      if (rx.rx_start) begin
        rx.rx_sr_pc = 1'b0;
        low_cnt = low_len;
      end else if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) begin
          rx.rx_sr_pc = 1'b1;
          rx_completed = 1'b1;
        end
      end
    end else if (model == 2) begin
      if (rx.rx_start_rt) begin
        rx.rx_sr_pc = 1'b0;
        rt_seen = 1'b1;
      end else if (rt_seen) begin
        rt_seen = 1'b0;
        low_cnt = 10;
      end else if (low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) begin
          rx.rx_sr_pc = 1'b1;
          rx_completed = 1'b1;
        end
      end
    end
  endtask

  task automatic set_cfg(input logic mode, input logic [31:0] dsize, input logic tst,
                         input logic [15:0] np, input logic [15:0] gap);
    cfg_mode     = mode;
    cfg_dsize    = dsize;
    cfg_test     = tst;
    cfg_npackets = np;
    cfg_gap      = gap;
    cfg_timeout  = 32'd0;
    model        = 0;
    low_cnt      = 0;
    rt_seen      = 1'b0;
    rx.rx_sr_pc  = 1'b1;
  endtask

  task automatic apply_reset();
    aresetn   = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    rx.rx_sr_pc = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    set_cfg(1'b0, 32'd0, 1'b0, 16'd0, 16'd0);
    aresetn   = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    checks++; if (rx.rx_start !== 1'b0) begin errors++; $display("FAIL reset_rx_start: got %b want 0", rx.rx_start); end
    checks++; if (rx.rx_start_rt !== 1'b0) begin errors++; $display("FAIL reset_rx_start_rt: got %b want 0", rx.rx_start_rt); end
    checks++; if (rx.rx_dsize !== 32'd0) begin errors++; $display("FAIL reset_rx_dsize: got %0d want 0", rx.rx_dsize); end
    checks++; if (rx.rx_test !== 1'b0) begin errors++; $display("FAIL reset_rx_test: got %b want 0", rx.rx_test); end
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_packet_burst();
    int pulses = 0, dones = 0, first_start = -1, last_cmpl = -1, min_gap = 1000000, post = 0;
    bit cfg_bad = 1'b0, expired = 1'b1;
    set_cfg(1'b0, 32'd256, 1'b1, 16'd3, 16'd4);
    model = 1; low_len = 258;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      rx_step();
      if (rx_completed) last_cmpl = cyc;
      if (rx.rx_start) begin
        pulses++;
        if (first_start < 0) first_start = cyc;
        else if (cyc - last_cmpl < min_gap) min_gap = cyc - last_cmpl;
      end
      if (busy && (rx.rx_dsize !== 32'd256 || rx.rx_test !== 1'b1)) cfg_bad = 1'b1;
      if (done) dones++;
      if (dones > 0) post++;
      if (post == 6) begin expired = 1'b0; break; end
    end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL burst_timeout: no done within budget, got %b want 0", expired); end
    checks++; if (first_start !== 2) begin errors++; $display("FAIL burst_start_latency: got %0d want 2", first_start); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL burst_pulses: got %0d want 3", pulses); end
    checks++; if (min_gap < 4) begin errors++; $display("FAIL burst_gap: got %0d want >=4", min_gap); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL burst_done_count: got %0d want 1", dones); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL burst_pkt_count: got %0d want 3", pkt_count); end
    checks++; if (cfg_bad !== 1'b0) begin errors++; $display("FAIL burst_rx_cfg_stable: got %b want 0", cfg_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_gap_zero();
    int pulses = 0, dones = 0, cmpl1 = -1, second = -1, post = 0;
    set_cfg(1'b0, 32'd8, 1'b0, 16'd2, 16'd0);
    model = 1; low_len = 8;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      rx_step();
      if (rx_completed && cmpl1 < 0) cmpl1 = cyc;
      if (rx.rx_start) begin
        pulses++;
        if (pulses == 2) second = cyc;
      end
      if (done) dones++;
      if (dones > 0) post++;
      if (post == 4) break;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL gap0_pulses: got %0d want 2", pulses); end
    checks++; if (second - cmpl1 !== 3) begin errors++; $display("FAIL gap0_restart_delay: got %0d want 3", second - cmpl1); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL gap0_done_count: got %0d want 1", dones); end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL gap0_pkt_count: got %0d want 2", pkt_count); end
  endtask

  task automatic test_realtime();
    int rt_cycles = 0, starts = 0, dones = 0, rise = -1, done_cyc = -1, post = 0;
    set_cfg(1'b1, 32'd64, 1'b0, 16'd0, 16'd0);
    model = 2;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      cmd_abort = (cyc == 100);
      rx_step();
      if (rx_completed) rise = cyc;
      if (rx.rx_start_rt) rt_cycles++;
      if (rx.rx_start) starts++;
      if (done) begin dones++; done_cyc = cyc; end
      if (dones > 0) post++;
      if (post == 4) break;
    end
    cmd_abort = 1'b0;
    checks++; if (rt_cycles < 95 || rt_cycles > 105) begin errors++; $display("FAIL rt_high_cycles: got %0d want 95..105", rt_cycles); end
    checks++; if (starts !== 0) begin errors++; $display("FAIL rt_no_rx_start: got %0d want 0", starts); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL rt_done_count: got %0d want 1", dones); end
    checks++; if ((done_cyc - rise) < 1 || (done_cyc - rise) > 2) begin errors++; $display("FAIL rt_done_latency: got %0d want 1..2", done_cyc - rise); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rt_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_abort_mid_packet();
    int pulses = 0, dones = 0, p = -1, cmpl = -1, done_cyc = -1, post = 0;
    set_cfg(1'b0, 32'd16, 1'b0, 16'd0, 16'd2);
    model = 1; low_len = 20;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      cmd_abort = (p > 0 && cyc == p + 5);
      rx_step();
      if (rx_completed) cmpl = cyc;
      if (rx.rx_start) begin pulses++; if (p < 0) p = cyc; end
      if (done) begin dones++; done_cyc = cyc; end
      if (dones > 0) post++;
      if (post == 10) break;
    end
    cmd_abort = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL abort_pkt_pulses: got %0d want 1", pulses); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL abort_pkt_done_count: got %0d want 1", dones); end
    checks++; if (done_cyc - cmpl !== 1) begin errors++; $display("FAIL abort_pkt_done_after_cmpl: got %0d want 1", done_cyc - cmpl); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL abort_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_abort_in_gap();
    int pulses = 0, dones = 0, cmpl = -1, done_cyc = -1, post = 0;
    set_cfg(1'b0, 32'd16, 1'b0, 16'd0, 16'd20);
    model = 1; low_len = 10;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      cmd_abort = (cmpl > 0 && cyc == cmpl + 3);
      rx_step();
      if (rx_completed && cmpl < 0) cmpl = cyc;
      if (rx.rx_start) pulses++;
      if (done) begin dones++; done_cyc = cyc; end
      if (dones > 0) post++;
      if (post == 30) break;
    end
    cmd_abort = 1'b0;
    checks++; if (done_cyc - cmpl !== 4) begin errors++; $display("FAIL abort_gap_done_cycle: got %0d want 4", done_cyc - cmpl); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL abort_gap_pulses: got %0d want 1", pulses); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL abort_gap_pkt_count: got %0d want 1", pkt_count); end
  endtask

  task automatic test_start_while_busy();
    int pulses = 0, dones = 0, post = 0;
    bit dsize_bad = 1'b0;
    set_cfg(1'b0, 32'd100, 1'b0, 16'd1, 16'd0);
    model = 1; low_len = 10;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge aclk);
      cmd_start = (cyc == 6);
      if (cyc == 6) begin cfg_dsize = 32'd999; cfg_mode = 1'b1; end
      rx_step();
      if (rx.rx_start) pulses++;
      if (busy && rx.rx_dsize !== 32'd100) dsize_bad = 1'b1;
      if (done) dones++;
      if (dones > 0) post++;
      if (post == 8) break;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    checks++; if (dsize_bad !== 1'b0) begin errors++; $display("FAIL busy_start_dsize: got %b want 0", dsize_bad); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", dones); end
    checks++; if (rx.rx_start_rt !== 1'b0) begin errors++; $display("FAIL busy_start_no_rt: got %b want 0", rx.rx_start_rt); end
  endtask

  task automatic test_start_abort_together();
    bit went_busy = 1'b0;
    set_cfg(1'b0, 32'd32, 1'b0, 16'd1, 16'd0);
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (busy || rx.rx_start) went_busy = 1'b1;
      @(negedge aclk);
    end
    checks++; if (went_busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle: got %b want 0", went_busy); end
  endtask

  task automatic test_reset_during_rt();
    bit saw_done = 1'b0;
    set_cfg(1'b1, 32'd48, 1'b1, 16'd0, 16'd0);
    cmd_start = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
    repeat (10) @(negedge aclk);
    checks++; if (rx.rx_start_rt !== 1'b1) begin errors++; $display("FAIL rst_rt_pre: got %b want 1", rx.rx_start_rt); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (rx.rx_start_rt !== 1'b0) begin errors++; $display("FAIL rst_rt_immediate: got %b want 0", rx.rx_start_rt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_rt_busy: got %b want 0", busy); end
    checks++; if (rx.rx_dsize !== 32'd0) begin errors++; $display("FAIL rst_rt_dsize: got %0d want 0", rx.rx_dsize); end
    checks++; if (rx.rx_test !== 1'b0) begin errors++; $display("FAIL rst_rt_test: got %b want 0", rx.rx_test); end
    @(negedge aclk);
    aresetn = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge aclk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_rt_idle_after: got %b want 0", saw_done); end
  endtask

  task automatic test_timeout();
    int err_cyc = -1, dones = 0;
    bit busy_end;
    set_cfg(1'b0, 32'd16, 1'b0, 16'd1, 16'd0);
    cfg_timeout = 32'd50;
    cmd_start = 1'b1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge aclk);
      cmd_start = 1'b0;
      if (err_timeout && err_cyc < 0) err_cyc = cyc;
      if (done) dones++;
    end
    busy_end = busy;
    checks++; if (dones !== 0) begin errors++; $display("FAIL timeout_no_done: got %0d want 0", dones); end
`ifdef LVDS_SEQ_TIMEOUT_EN
    checks++; if (err_cyc !== 53) begin errors++; $display("FAIL timeout_err_cycle: got %0d want 53", err_cyc); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b want 0", busy_end); end
    cmd_start = 1'b1;
    @(negedge aclk);
    cmd_start = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_err_cleared: got %b want 0", err_timeout); end
`else
    checks++; if (err_cyc !== -1) begin errors++; $display("FAIL timeout_err_tied_low: got %0d want -1", err_cyc); end
    checks++; if (busy_end !== 1'b1) begin errors++; $display("FAIL timeout_unbounded_wait: got %b want 1", busy_end); end
`endif
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_packet_burst();
    test_gap_zero();
    test_realtime();
    test_abort_mid_packet();
    test_abort_in_gap();
    test_start_while_busy();
    test_start_abort_together();
    test_reset_during_rt();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_input_capture_sequencer.md
LVDS_INPUT_CAPTURE_SEQUENCER -- requirements
Module: lvds_input_capture_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the packet-count and gap fields.
REQ-002 SHALL have port aclk, in, 1: single clock, rising edge, same domain as the receiver AXIS clock.
REQ-003 SHALL have port aresetn, in, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port cmd_start, in, 1: one-cycle pulse that begins a burst.
REQ-005 SHALL have port cmd_abort, in, 1: one-cycle pulse that ends a burst.
REQ-006 SHALL have port cfg_mode, in, 1: 0 selects packet mode, 1 selects real-time mode.
REQ-007 SHALL have ports cfg_dsize (in, 32, words per packet) and cfg_test (in, 1, counter test pattern).
REQ-008 SHALL have ports cfg_npackets (in, CNT_W, packets per burst; 0 = continuous) and cfg_gap (in, CNT_W, idle cycles between packets).
REQ-009 SHALL have port cfg_timeout, in, 32: watchdog limit in cycles; 0 disables the watchdog.
REQ-010 SHALL have port rx_sr_pc, in, 1: receiver packet-complete/idle flag.
REQ-011 SHALL have ports rx_start (out, 1, pulse), rx_start_rt (out, 1, level), rx_dsize (out, 32) and rx_test (out, 1), all driving the receiver.
REQ-012 SHALL have status ports busy (out, 1), done (out, 1, pulse), err_timeout (out, 1, sticky) and pkt_count (out, CNT_W).

Function
REQ-013 SHALL implement states IDLE, ARM, ISSUE, WAIT_LOW, WAIT_HIGH, GAP, RT, DRAIN and DONE, with all outputs registered.
REQ-014 IDLE: on cmd_start && !cmd_abort, SHALL latch cfg_dsize, cfg_test, cfg_npackets, cfg_gap and cfg_mode, clear pkt_count and err_timeout, and go to ARM; otherwise it stays in IDLE.
REQ-015 rx_dsize and rx_test SHALL be driven only from the latched values, so they stay stable for the whole burst.
REQ-016 ARM: when rx_sr_pc=1, SHALL go to ISSUE if the latched mode=0, or to RT if the latched mode=1.
REQ-017 ISSUE: SHALL hold rx_start=1 for exactly one cycle, then go to WAIT_LOW; a cmd_start on cycle 0 therefore gives rx_start on cycle 2 when rx_sr_pc is already high.
REQ-018 WAIT_LOW: when rx_sr_pc=0 (receiver has accepted the start), SHALL go to WAIT_HIGH.
REQ-019 WAIT_HIGH: when rx_sr_pc=1, SHALL increment pkt_count (saturating at all-ones) and then evaluate the exit conditions below.
REQ-020 WAIT_HIGH exit: SHALL go to DONE if an abort is pending, or if npackets≠0 and the incremented count equals npackets; otherwise SHALL go to GAP.
REQ-021 GAP: SHALL wait gap cycles and then go to ARM; gap=0 SHALL go to ARM on the next cycle.
REQ-022 RT: SHALL hold rx_start_rt=1; on cmd_abort SHALL drop rx_start_rt on the next cycle and go to DRAIN.
REQ-023 DRAIN: when rx_sr_pc=1, SHALL increment pkt_count and go to DONE.
REQ-024 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 cmd_abort in packet mode SHALL set an abort-pending flag; the packet in flight SHALL complete, because the receiver cannot be cancelled mid-packet.
REQ-027 cmd_abort in ARM or GAP SHALL go directly to DONE.
REQ-028 cmd_start while busy SHALL be ignored.
REQ-029 cmd_start and cmd_abort asserted together in IDLE SHALL be ignored (abort wins).

Reset
REQ-030 While aresetn=0, SHALL force state=IDLE, all rx_* outputs=0, busy=0, done=0, err_timeout=0, pkt_count=0 and all latched fields=0.
REQ-031 Reset asserted mid-burst SHALL drop rx_start_rt immediately, with no done pulse; after release the block SHALL wait in IDLE.

Configuration
REQ-032 Macro LVDS_SEQ_TIMEOUT_EN defined: SHALL count cycles spent in ARM, WAIT_LOW, WAIT_HIGH or DRAIN, restarting the count on every state change.
REQ-033 With the macro defined and cfg_timeout≠0: when the count reaches cfg_timeout, SHALL set err_timeout=1, clear rx_start_rt and go to IDLE with no done pulse.
REQ-034 Macro not defined: SHALL include no watchdog counter, SHALL tie err_timeout to 0, SHALL ignore cfg_timeout, and waits SHALL be unbounded.

Verification
REQ-035 Packet burst: mode=0, dsize=256, npackets=3, gap=4, rx_sr_pc model low for 258 cycles after each rx_start -> exactly 3 rx_start pulses, each at least 4 cycles after the previous completion; pkt_count=3; one done pulse; rx_dsize=256 throughout.
REQ-036 Real-time run: mode=1, cmd_start, then cmd_abort 100 cycles later, with rx_sr_pc returning high 10 cycles after rx_start_rt falls -> rx_start_rt high for ~100 cycles; done 1-2 cycles after rx_sr_pc rises; pkt_count=1.
REQ-037 Abort mid-packet: mode=0, npackets=0, cmd_abort during WAIT_HIGH -> no further rx_start; done follows the completion; pkt_count=1.
REQ-038 Timeout (macro defined): cfg_timeout=50, rx_sr_pc held high after rx_start -> err_timeout=1 at WAIT_LOW+50 cycles; state returns to IDLE with no done pulse; the next cmd_start clears err_timeout.
REQ-039 Edge cases: cmd_start together with cmd_abort in IDLE -> busy stays 0; aresetn pulsed low during RT -> rx_start_rt=0 in the same cycle and all outputs at reset values.
